react_ctrl: RTL and testbench
=============================

Name: react_ctrl

Overview:
- Initiator side of the reaction-test measurement interface.
- Picks a pseudo-random wait, then lights one target LED and issues the one-cycle det_start to the timing block.
- Waits for det_end, then latches the 4-digit BCD reaction time and tracks the best (lowest) score.
- Detects early presses (fouls) and aborts/restarts a run on user request.

Parameters:
- CLK_PER_MS, 12000, clock cycles per millisecond (12 MHz system clock).
- MIN_WAIT_MS, 1000, minimum wait before the target lights, in ms.
- RAND_MASK, 11'h7FF, mask applied to LFSR bits for the random extra wait, in ms.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock, 12 MHz.
- rstn  in  1  asynchronous active-low reset.
- start_btn  in  1  debounced single-cycle start/abort request, active high.
- btn_deb  in  8  debounced player buttons; active low (pressed = 0).
- det_end  in  1  one-cycle measurement-finished pulse from the timer.
- ctrl_in  in  16  packed BCD reaction time {thousands, hundreds, tens, units} in ms.
- det_start  out  1  one-cycle pulse that starts the timer.
- restart  out  1  one-cycle pulse that aborts the timer (timer then suppresses det_end).
- bit_sel  out  8  one-hot target LED; timer ends when btn_deb == ~bit_sel.
- result  out  16  last valid BCD reaction time.
- result_vld  out  1  one-cycle pulse when result updates.
- best  out  16  lowest valid BCD time since reset.
- foul  out  1  level; set by early press, cleared on next run start.
- timeout  out  1  level; set when ctrl_in==16'h0000 at det_end, cleared on next run start.
- busy  out  1  high in WAIT, ARM, MEAS.

Behaviour:
- Reset values: all outputs 0 except best=16'h9999. State=IDLE. lfsr=LFSR_SEED; all counters 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every clock including in IDLE. Never all-zero.
- States: IDLE, WAIT, ARM, MEAS, DONE, FOUL.
- IDLE/DONE/FOUL + start_btn -> WAIT, next edge. On entry:
  - wait_ms = MIN_WAIT_MS + (lfsr[10:0] & RAND_MASK).
  - tgt = lfsr[13:11] mod 8.
  - foul and timeout cleared; ms counters cleared.
- WAIT:
  - ms prescaler counts 0..CLK_PER_MS-1; at wrap, ms counter increments.
  - Any btn_deb != 8'hFF -> FOUL, foul=1. This has priority over expiry and start_btn.
  - start_btn (no press) -> IDLE, no restart pulse.
  - ms counter == wait_ms-1 at prescaler wrap -> ARM.
- ARM, exactly 1 cycle: det_start=1; bit_sel = 1<<tgt from this cycle on. Next state MEAS.
- MEAS:
  - det_end -> result=ctrl_in, result_vld=1 same edge; then DONE.
    - If ctrl_in==16'h0000: timeout=1, best unchanged.
    - Else if ctrl_in < best (plain 16-bit unsigned compare; valid for packed BCD): best=ctrl_in.
  - start_btn with no det_end -> restart=1 for 1 cycle; then IDLE.
  - det_end and start_btn in the same cycle: det_end wins, start ignored, no restart.
- bit_sel: 0 in IDLE, WAIT, FOUL; held in ARM, MEAS, DONE; cleared on entry to WAIT.
- det_start, restart and result_vld are registered, single-cycle, never overlapping.
- Latency: start_btn to det_start = wait_ms*CLK_PER_MS + 2 cycles (±1 for prescaler phase, fixed by clearing it at WAIT entry). det_end to result_vld = 1 cycle.
- Async reset mid-run: everything returns to reset values immediately, including best. No restart pulse is emitted.
- Inputs are synchronous to clk. No synchronizers inside this block.

Test Plan:
1. CLK_PER_MS=4, MIN_WAIT_MS=3, RAND_MASK=0; start_btn -> det_start exactly 14 cycles later (±1); bit_sel one-hot, nonzero from that cycle; busy=1.
2. In MEAS, det_end with ctrl_in=16'h0234 -> result=16'h0234, result_vld single pulse, best 16'h9999->16'h0234. Second run with ctrl_in=16'h0301 -> best stays 16'h0234.
3. btn_deb=8'hFE during WAIT -> FOUL, foul=1, no det_start, bit_sel=0. Next start_btn clears foul.
4. start_btn in MEAS -> restart=1 for one cycle, state IDLE, result unchanged. Same-cycle det_end+start_btn -> result latched, restart=0.
5. det_end with ctrl_in=16'h0000 -> timeout=1, result=0, best unchanged.
6. rstn low during MEAS -> det_start, restart, bit_sel, busy = 0 immediately; best=16'h9999; LFSR back to 16'hACE1.

Source files
------------

// File: rtl/react_ctrl_if.sv
// Measurement-timer handshake between the reaction controller (master)
// and the timing block (slave).
interface react_ctrl_if;
    logic        det_start;
    logic        restart;
    logic [7:0]  bit_sel;
    logic        det_end;
    logic [15:0] ctrl_in;

    modport master (
        output det_start,
        output restart,
        output bit_sel,
        input  det_end,
        input  ctrl_in
    );

    modport slave (
        input  det_start,
        input  restart,
        input  bit_sel,
        output det_end,
        output ctrl_in
    );
endinterface

// File: rtl/react_ctrl.sv
// Reaction-test initiator: random wait, target LED + timer kick, result
// capture with best-score tracking, foul detection and user abort.
//
// state | meaning
// IDLE  | no run in progress, waiting for start_btn
// WAIT  | random wait running, any press is a foul
// ARM   | single cycle: det_start pulses, target LED lights
// MEAS  | timer running, waiting for det_end or an abort
// DONE  | result captured, target LED still held
// FOUL  | early press seen, waiting for start_btn
module react_ctrl #(
    parameter int          CLK_PER_MS  = 12000,
    parameter int          MIN_WAIT_MS = 1000,
    parameter logic [10:0] RAND_MASK   = 11'h7FF,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start_btn,
    input  logic [7:0]          btn_deb,
    react_ctrl_if.master        tmr,
    output logic [15:0]         result,
    output logic                result_vld,
    output logic [15:0]         best,
    output logic                foul,
    output logic                timeout,
    output logic                busy
);
    localparam int PSC_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(CLK_PER_MS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_ARM, S_MEAS, S_DONE, S_FOUL
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [PSC_W-1:0]   psc_q, psc_d;
    logic [15:0]        ms_q, ms_d;
    logic [15:0]        wait_ms_q, wait_ms_d;
    logic [2:0]         tgt_q, tgt_d;
    logic [7:0]         bit_sel_q, bit_sel_d;
    logic               det_start_q, det_start_d;
    logic               restart_q, restart_d;
    logic [15:0]        result_q, result_d;
    logic               result_vld_q, result_vld_d;
    logic [15:0]        best_q, best_d;
    logic               foul_q, foul_d;
    logic               timeout_q, timeout_d;

    logic               psc_wrap;
    logic               lfsr_fb;

    assign psc_wrap = (psc_q == PSC_MAX);
    assign lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[14:0], lfsr_fb};
        psc_d        = psc_q;
        ms_d         = ms_q;
        wait_ms_d    = wait_ms_q;
        tgt_d        = tgt_q;
        bit_sel_d    = bit_sel_q;
        det_start_d  = 1'b0;
        restart_d    = 1'b0;
        result_d     = result_q;
        result_vld_d = 1'b0;
        best_d       = best_q;
        foul_d       = foul_q;
        timeout_d    = timeout_q;

        case (state_q)
            S_IDLE, S_DONE, S_FOUL: begin
                if (start_btn) begin
                    state_d   = S_WAIT;
                    wait_ms_d = 16'(MIN_WAIT_MS) + {5'd0, lfsr_q[10:0] & RAND_MASK};
                    tgt_d     = lfsr_q[13:11];
                    foul_d    = 1'b0;
                    timeout_d = 1'b0;
                    psc_d     = '0;
                    ms_d      = '0;
                    bit_sel_d = '0;
                end
            end
            S_WAIT: begin
                // An early press outranks both expiry and a user abort.
                if (btn_deb != 8'hFF) begin
                    state_d = S_FOUL;
                    foul_d  = 1'b1;
                end else if (start_btn) begin
                    state_d = S_IDLE;
                end else if (psc_wrap) begin
                    psc_d = '0;
                    if (ms_q == wait_ms_q - 16'd1) begin
                        state_d     = S_ARM;
                        det_start_d = 1'b1;
                        bit_sel_d   = 8'd1 << tgt_q;
                    end else begin
                        ms_d = ms_q + 16'd1;
                    end
                end else begin
                    psc_d = psc_q + PSC_W'(1);
                end
            end
            S_ARM: begin
                state_d = S_MEAS;
            end
            S_MEAS: begin
                // det_end wins over a simultaneous abort request.
                if (tmr.det_end) begin
                    state_d      = S_DONE;
                    result_d     = tmr.ctrl_in;
                    result_vld_d = 1'b1;
                    if (tmr.ctrl_in == 16'h0000) begin
                        timeout_d = 1'b1;
                    end else if (tmr.ctrl_in < best_q) begin
                        best_d = tmr.ctrl_in;
                    end
                end else if (start_btn) begin
                    state_d   = S_IDLE;
                    restart_d = 1'b1;
                    bit_sel_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset restores power-up values, best included.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_SEED;
            psc_q        <= '0;
            ms_q         <= '0;
            wait_ms_q    <= '0;
            tgt_q        <= '0;
            bit_sel_q    <= '0;
            det_start_q  <= 1'b0;
            restart_q    <= 1'b0;
            result_q     <= '0;
            result_vld_q <= 1'b0;
            best_q       <= 16'h9999;
            foul_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            psc_q        <= psc_d;
            ms_q         <= ms_d;
            wait_ms_q    <= wait_ms_d;
            tgt_q        <= tgt_d;
            bit_sel_q    <= bit_sel_d;
            det_start_q  <= det_start_d;
            restart_q    <= restart_d;
            result_q     <= result_d;
            result_vld_q <= result_vld_d;
            best_q       <= best_d;
            foul_q       <= foul_d;
            timeout_q    <= timeout_d;
        end
    end

    assign tmr.det_start = det_start_q;
    assign tmr.restart   = restart_q;
    assign tmr.bit_sel   = bit_sel_q;
    assign result        = result_q;
    assign result_vld    = result_vld_q;
    assign best          = best_q;
    assign foul          = foul_q;
    assign timeout       = timeout_q;
    assign busy          = (state_q == S_WAIT) || (state_q == S_ARM) || (state_q == S_MEAS);
endmodule

// File: tb/tb_react_ctrl.sv
// Scoreboard bench for react_ctrl with a short (3 ms of 4 cycles) fixed wait.
module tb_react_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_btn = 1'b0;
    logic [7:0]  btn_deb = 8'hFF;
    logic [15:0] result;
    logic        result_vld;
    logic [15:0] best;
    logic        foul;
    logic        timeout;
    logic        busy;

    react_ctrl_if tmr_if();

    react_ctrl #(
        .CLK_PER_MS  (4),
        .MIN_WAIT_MS (3),
        .RAND_MASK   (11'h000),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_btn  (start_btn),
        .btn_deb    (btn_deb),
        .tmr        (tmr_if.master),
        .result     (result),
        .result_vld (result_vld),
        .best       (best),
        .foul       (foul),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [7:0]  sel;
        logic [31:0] t0;
    } ds_t;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] bst;
        logic        tmo;
    } res_t;

    ds_t  sel_q[$];
    res_t res_q[$];

    // Reference LFSR: Fibonacci, taps 16,14,13,11, seed ACE1.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_ds = 0, n_rs = 0, n_vld = 0;
    logic prev_ds = 1'b0, prev_rs = 1'b0, prev_vld = 1'b0;
    logic [15:0] best_m = 16'h9999;
    logic [7:0]  last_sel = 8'h00;

    // Output monitor: pops expectations when the DUT pulses.
    always @(negedge clk) begin
        ds_t  d;
        res_t r;
        int   lat;
        if (rstn) begin
            if (tmr_if.det_start || tmr_if.restart || result_vld)
                check_eq("pulse_excl", $countones({tmr_if.det_start, tmr_if.restart, result_vld}), 1);
            if (tmr_if.det_start) begin
                n_ds++;
                check_eq("ds_single", prev_ds, 0);
                check_eq("ds_expected", sel_q.size() > 0, 1);
                if (sel_q.size() > 0) begin
                    d   = sel_q.pop_front();
                    lat = cyc - int'(d.t0);
                    check_eq("bit_sel", tmr_if.bit_sel, d.sel);
                    check_eq("ds_latency_13_15", (lat >= 13 && lat <= 15), 1);
                    check_eq("busy_arm", busy, 1);
                end
            end
            if (tmr_if.restart) begin
                n_rs++;
                check_eq("rs_single", prev_rs, 0);
            end
            if (result_vld) begin
                n_vld++;
                check_eq("vld_single", prev_vld, 0);
                check_eq("res_expected", res_q.size() > 0, 1);
                if (res_q.size() > 0) begin
                    r = res_q.pop_front();
                    check_eq("result", result, r.res);
                    check_eq("best", best, r.bst);
                    check_eq("timeout", timeout, r.tmo);
                end
            end
            prev_ds  = tmr_if.det_start;
            prev_rs  = tmr_if.restart;
            prev_vld = result_vld;
        end else begin
            prev_ds  = 1'b0;
            prev_rs  = 1'b0;
            prev_vld = 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_run(input bit expect_ds);
        ds_t d;
        step();
        if (expect_ds) begin
            d.sel    = 8'd1 << m_lfsr[13:11];
            d.t0     = cyc;
            last_sel = d.sel;
            sel_q.push_back(d);
        end
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
    endtask

    // Returns during the first MEAS cycle (or after the bound expires).
    task automatic wait_ds();
        int n0;
        n0 = n_ds;
        for (int i = 0; i < 100 && n_ds == n0; i++) step();
        check_eq("ds_seen", n_ds, n0 + 1);
        step();
    endtask

    task automatic meas_end(input logic [15:0] val, input bit with_start);
        res_t r;
        int   v0;
        v0    = n_vld;
        r.res = val;
        r.tmo = (val == 16'h0000);
        if (val != 16'h0000 && val < best_m) best_m = val;
        r.bst = best_m;
        res_q.push_back(r);
        tmr_if.det_end = 1'b1;
        tmr_if.ctrl_in = val;
        start_btn      = with_start;
        step();
        tmr_if.det_end = 1'b0;
        start_btn      = 1'b0;
        check_eq("vld_seen", n_vld, v0 + 1);
    endtask

    initial begin
        int n0, r0, v0;
        tmr_if.det_end = 1'b0;
        tmr_if.ctrl_in = 16'h0000;

        repeat (3) step();
        check_eq("rst_result", result, 16'h0000);
        check_eq("rst_best", best, 16'h9999);
        check_eq("rst_vld", result_vld, 0);
        check_eq("rst_foul", foul, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_bit_sel", tmr_if.bit_sel, 8'h00);
        check_eq("rst_det_start", tmr_if.det_start, 0);
        check_eq("rst_restart", tmr_if.restart, 0);
        rstn = 1'b1;

        // First run: best improves from 9999.
        start_run(1);
        check_eq("wait_busy", busy, 1);
        check_eq("wait_bit_sel", tmr_if.bit_sel, 8'h00);
        wait_ds();
        meas_end(16'h0234, 0);
        check_eq("done_bit_sel_held", tmr_if.bit_sel, last_sel);
        check_eq("done_busy", busy, 0);

        // Second run: slower time leaves best alone.
        start_run(1);
        wait_ds();
        meas_end(16'h0301, 0);
        check_eq("best_kept", best, 16'h0234);

        // Foul: early press during WAIT.
        start_run(0);
        step();
        step();
        btn_deb = 8'hFE;
        step();
        btn_deb = 8'hFF;
        check_eq("foul_set", foul, 1);
        check_eq("foul_bit_sel", tmr_if.bit_sel, 8'h00);
        check_eq("foul_busy", busy, 0);
        n0 = n_ds;
        repeat (20) step();
        check_eq("foul_no_ds", n_ds, n0);
        check_eq("foul_held", foul, 1);

        // Abort in MEAS.
        start_run(1);
        check_eq("foul_cleared", foul, 0);
        wait_ds();
        r0 = n_rs;
        v0 = n_vld;
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
        check_eq("abort_restart", n_rs, r0 + 1);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_bit_sel", tmr_if.bit_sel, 8'h00);
        check_eq("abort_result", result, 16'h0301);
        check_eq("abort_no_vld", n_vld, v0);
        step();
        check_eq("abort_rs_low", tmr_if.restart, 0);

        // det_end and start_btn together: result wins, no restart.
        start_run(1);
        wait_ds();
        r0 = n_rs;
        meas_end(16'h0150, 1);
        check_eq("same_no_restart", n_rs, r0);
        step();
        check_eq("same_no_restart_late", n_rs, r0);
        check_eq("same_busy", busy, 0);

        // Timeout result.
        start_run(1);
        wait_ds();
        meas_end(16'h0000, 0);
        check_eq("tmo_level", timeout, 1);
        check_eq("tmo_result", result, 16'h0000);
        check_eq("tmo_best", best, 16'h0150);

        // New run clears timeout; async reset mid-MEAS.
        start_run(1);
        check_eq("tmo_cleared", timeout, 0);
        wait_ds();
        #2;
        rstn = 1'b0;
        #1;
        check_eq("arst_det_start", tmr_if.det_start, 0);
        check_eq("arst_restart", tmr_if.restart, 0);
        check_eq("arst_bit_sel", tmr_if.bit_sel, 8'h00);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_best", best, 16'h9999);
        check_eq("arst_result", result, 16'h0000);
        sel_q.delete();
        res_q.delete();
        best_m = 16'h9999;
        step();
        step();
        rstn = 1'b1;

        // Target after reset follows the LFSR restarted from its seed.
        start_run(1);
        wait_ds();
        meas_end(16'h0777, 0);
        check_eq("post_rst_best", best, 16'h0777);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
